// File: rtl/four_bank_mem_responder.sv
// Four-bank interleaved word store for the cache main-memory port.
// Ports: clk, rst_n (async low), rd/wr/addr/data_in request,
//   data_out/rd_valid read return (2 cycles after accept),
//   stall (combinational back-pressure), busy[3:0] per bank,
//   err (pulse one cycle after an illegal request).
module four_bank_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int BANK_BUSY      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        rd_valid,
  output logic        stall,
  output logic [3:0]  busy,
  output logic        err
);

  localparam int CW    = $clog2(BANK_BUSY);
  localparam int DEPTH = 1 << MEM_WORDS_LOG2;
  localparam logic [CW-1:0] LOAD = CW'(BANK_BUSY - 1);

  typedef logic [MEM_WORDS_LOG2-1:0] idx_t;

  typedef struct packed {
    logic v;
    idx_t idx;
  } rd_req_t;

  logic [15:0] mem [DEPTH];

  logic [1:0]  bank;
  idx_t        idx;
  logic        legal;
  logic        illegal;
  logic        acc;
  logic        rd_acc;
  logic        wr_acc;
  rd_req_t     p1;
  logic        p2_v;
  logic [15:0] p2_data;

  assign bank = addr[2:1];
  assign idx  = addr[MEM_WORDS_LOG2:1];

  always_comb begin
    legal   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      rd & wr:              illegal = 1'b1;
      (rd ^ wr) & addr[0]:  illegal = 1'b1;
      (rd ^ wr) & ~addr[0]: legal   = 1'b1;
      default: ;
    endcase
  end

  assign stall  = legal & busy[bank];
  assign acc    = legal & ~busy[bank];
  assign rd_acc = acc & rd;
  assign wr_acc = acc & wr;

  // Counter holds BANK_BUSY-1 after the accept edge, so the
  // bank frees up exactly BANK_BUSY cycles after acceptance.
  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [CW-1:0] cnt;

    assign busy[b] = (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (acc && (bank == 2'(b))) begin
        cnt <= LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  // Storage is deliberately outside reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (p1.v) begin
      p2_data <= mem[p1.idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1   <= '0;
      p2_v <= 1'b0;
      err  <= 1'b0;
    end else begin
      p1   <= '{v: rd_acc, idx: idx};
      p2_v <= p1.v;
      err  <= illegal;
    end
  end

  assign rd_valid = p2_v;
  assign data_out = p2_v ? p2_data : 16'h0000;

endmodule

// File: tb/tb_four_bank_mem_responder.sv
// Bench for four_bank_mem_responder: per-cycle vector table
// with a read-return scoreboard and a mid-operation reset.
module tb_four_bank_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  four_bank_mem_responder #(
    .MEM_WORDS_LOG2(10),
    .BANK_BUSY(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd(rd),
    .wr(wr),
    .addr(addr),
    .data_in(data_in),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .stall(stall),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        stall;
    logic [3:0]  busy;
    logic        err;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } sb_t;

  vec_t        tbl[$];
  sb_t         q[$];
  logic [15:0] shadow [1024];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_n = 0;

  function automatic void add(
    input logic rd_i, input logic wr_i,
    input logic [15:0] a, input logic [15:0] d,
    input logic st, input logic [3:0] bz,
    input logic er);
    vec_t v;
    v.rd = rd_i; v.wr = wr_i; v.addr = a; v.din = d;
    v.stall = st; v.busy = bz; v.err = er;
    tbl.push_back(v);
  endfunction

  function automatic void idle(
    input logic [3:0] bz, input logic er);
    add(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, bz, er);
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               name, cyc_n, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    logic       lg;
    logic [9:0] ix;
    sb_t        e;
    @(negedge clk);
    rd = v.rd; wr = v.wr;
    addr = v.addr; data_in = v.din;
    #1;
    chk("stall", 16'(stall), 16'(v.stall));
    chk("busy", 16'(busy), 16'(v.busy));
    chk("err", 16'(err), 16'(v.err));
    if (q.size() > 0 && q[0].due == cyc_n) begin
      chk("rd_valid", 16'(rd_valid), 16'h1);
      chk("data_out", data_out, q[0].data);
      void'(q.pop_front());
    end else begin
      chk("rd_valid", 16'(rd_valid), 16'h0);
      chk("data_idle", data_out, 16'h0);
    end
    lg = (v.rd ^ v.wr) & ~v.addr[0];
    ix = v.addr[10:1];
    if (lg && !v.stall) begin
      if (v.wr) shadow[ix] = v.din;
      else begin
        e.due = cyc_n + 2;
        e.data = shadow[ix];
        q.push_back(e);
      end
    end
    cyc_n++;
  endtask

  initial begin
    // test 1: write bank1, read back after bank frees
    add(0, 1, 16'h0102, 16'hBEEF, 0, 4'h0, 0);
    idle(4'h2, 0); idle(4'h2, 0); idle(4'h2, 0);
    add(1, 0, 16'h0102, 16'h0, 0, 4'h0, 0);
    idle(4'h2, 0); idle(4'h2, 0); idle(4'h2, 0);
    idle(4'h0, 0);
    // test 2: preload four banks, rotate reads
    add(0, 1, 16'h0000, 16'h1111, 0, 4'h0, 0);
    add(0, 1, 16'h0002, 16'h2222, 0, 4'h1, 0);
    add(0, 1, 16'h0004, 16'h3333, 0, 4'h3, 0);
    add(0, 1, 16'h0006, 16'h4444, 0, 4'h7, 0);
    idle(4'hE, 0); idle(4'hC, 0); idle(4'h8, 0);
    add(1, 0, 16'h0000, 16'h0, 0, 4'h0, 0);
    add(1, 0, 16'h0002, 16'h0, 0, 4'h1, 0);
    add(1, 0, 16'h0004, 16'h0, 0, 4'h3, 0);
    add(1, 0, 16'h0006, 16'h0, 0, 4'h7, 0);
    idle(4'hE, 0); idle(4'hC, 0); idle(4'h8, 0);
    // test 3: stall on busy bank0
    add(0, 1, 16'h0018, 16'h5555, 0, 4'h0, 0);
    idle(4'h1, 0); idle(4'h1, 0); idle(4'h1, 0);
    add(0, 1, 16'h0010, 16'h6666, 0, 4'h0, 0);
    add(1, 0, 16'h0018, 16'h0, 1, 4'h1, 0);
    add(1, 0, 16'h0018, 16'h0, 1, 4'h1, 0);
    add(1, 0, 16'h0018, 16'h0, 1, 4'h1, 0);
    add(1, 0, 16'h0018, 16'h0, 0, 4'h0, 0);
    idle(4'h1, 0); idle(4'h1, 0); idle(4'h1, 0);
    idle(4'h0, 0);
    // test 4: illegal requests
    add(1, 1, 16'h0002, 16'h9999, 0, 4'h0, 0);
    idle(4'h0, 1); idle(4'h0, 0); idle(4'h0, 0);
    idle(4'h0, 0);
    add(1, 0, 16'h0003, 16'h0, 0, 4'h0, 0);
    idle(4'h0, 1); idle(4'h0, 0);
    add(0, 1, 16'h0004, 16'h7777, 0, 4'h0, 0);
    add(1, 1, 16'h0004, 16'h1234, 0, 4'h4, 0);
    add(0, 1, 16'h0005, 16'h4321, 0, 4'h4, 1);
    idle(4'h4, 1); idle(4'h0, 0);
    add(1, 0, 16'h0004, 16'h0, 0, 4'h0, 0);
    idle(4'h4, 0); idle(4'h4, 0); idle(4'h4, 0);
    idle(4'h0, 0);
    // test 6: address aliasing above bit 10
    add(0, 1, 16'h0800, 16'hA5A5, 0, 4'h0, 0);
    idle(4'h1, 0); idle(4'h1, 0); idle(4'h1, 0);
    add(1, 0, 16'h0000, 16'h0, 0, 4'h0, 0);
    idle(4'h1, 0); idle(4'h1, 0); idle(4'h1, 0);
    idle(4'h0, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_valid", 16'(rd_valid), 16'h0);
    chk("rst_data", data_out, 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // test 5: async reset with reads in flight
    add(1, 0, 16'h0004, 16'h0, 0, 4'h0, 0);
    add(1, 0, 16'h0000, 16'h0, 0, 4'h4, 0);
    cyc(tbl[tbl.size()-2]);
    cyc(tbl[tbl.size()-1]);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    #1;
    chk("pre_rst_valid", 16'(rd_valid), 16'h1);
    chk("pre_rst_data", data_out, 16'h7777);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_valid", 16'(rd_valid), 16'h0);
    chk("mid_rst_data", data_out, 16'h0);
    chk("mid_rst_err", 16'(err), 16'h0);
    q.delete();
    cyc_n++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(4'h0, 0); idle(4'h0, 0);
    idle(4'h0, 0); idle(4'h0, 0);
    add(1, 0, 16'h0004, 16'h0, 0, 4'h0, 0);
    idle(4'h4, 0); idle(4'h4, 0); idle(4'h4, 0);
    idle(4'h0, 0);
    for (int i = tbl.size() - 9; i < tbl.size(); i++)
      cyc(tbl[i]);

    chk("sb_drained", 16'(q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
